// File: rtl/alu_driver.sv
// alu_driver: debounces a start button and sequences operands/opcodes into an
// external combinational ALU, capturing each result into LEDs and an
// 8-entry result buffer indexed by opcode.
module alu_driver #(
  parameter int DEB_CYCLES = 4,
  parameter int SETTLE     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw1,
  input  logic [3:0] sw2,
  input  logic [2:0] sw3,
  input  logic       mode,
  input  logic       btn,
  output logic [3:0] da,
  output logic [3:0] db,
  output logic [2:0] ALU_ctr,
  input  logic [3:0] ALUout,
  input  logic       cout,
  input  logic       overflow,
  input  logic       less,
  input  logic       zero,
  output logic [3:0] led1,
  output logic [1:0] led2,
  output logic [1:0] led3,
  output logic       busy,
  output logic       done,
  input  logic [2:0] rd_sel,
  output logic [7:0] rd_data
);

  localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LAST    = CW'(DEB_CYCLES - 1);
  localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t        state;
  logic [1:0]    sync;
  logic          deb;
  logic          deb_d;
  logic [CW-1:0] deb_cnt;
  logic          go;
  logic          sweep;
  logic [3:0]    settle_cnt;
  logic [7:0]    buffer [8];
  logic [7:0]    result;

  assign result  = {ALUout, cout, overflow, less, zero};
  assign go      = deb & ~deb_d;
  assign rd_data = buffer[rd_sel];

  // Two-flop synchronizer bringing the asynchronous button into the clock domain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync <= 2'b00;
    else      sync <= {sync[0], btn};
  end

  // Debounce: the level must differ from the debounced level for DEB_CYCLES in a row
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb     <= 1'b0;
      deb_d   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      deb_d <= deb;
      if (sync[1] == deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb     <= ~deb;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + CW'(1);
      end
    end
  end

  // Operation sequencer: latch switches, hold operands SETTLE cycles, capture, repeat for sweeps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sweep      <= 1'b0;
      settle_cnt <= '0;
      da         <= '0;
      db         <= '0;
      ALU_ctr    <= '0;
      led1       <= '0;
      led2       <= '0;
      led3       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      for (int i = 0; i < 8; i++) buffer[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (go) begin
            da         <= sw1;
            db         <= sw2;
            ALU_ctr    <= mode ? 3'd0 : sw3;
            sweep      <= mode;
            settle_cnt <= '0;
            busy       <= 1'b1;
            state      <= DRIVE;
          end
        end
        DRIVE: begin
          if (settle_cnt == SETTLE_LAST) state <= CAPTURE;
          else                           settle_cnt <= settle_cnt + 4'd1;
        end
        CAPTURE: begin
          buffer[ALU_ctr] <= result;
          led1            <= ALUout;
          led2            <= {cout, overflow};
          led3            <= {less, zero};
          if (sweep && (ALU_ctr != 3'd7)) begin
            ALU_ctr    <= ALU_ctr + 3'd1;
            settle_cnt <= '0;
            state      <= DRIVE;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
